echo_controller: RTL and testbench
==================================

# echo_controller

Sequencing controller for the stereo echo effect. It takes one left/right sample pair per audio frame and drives an external single-port sample RAM as a circular delay line, with left and right interleaved. For each frame it reads the delayed pair, mixes it with the input at a programmable gain, writes the new pair back and presents the mixed output. It sits between the codec receive path and the codec transmit path, in place of the plain pass-through FIFOs.

## Interface
- d_width, 24, sample width in bits, two's complement
- address_width, 4, frame-pointer width in bits
- ram_depth, 16, delay-line depth in frames; must equal 2**address_width

- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- i_valid  input  1  single-cycle frame strobe
- i_l_data  input  d_width  left input sample, signed
- i_r_data  input  d_width  right input sample, signed
- delay_len  input  address_width  delay in frames; 0 means ram_depth frames
- gain  input  4  echo gain, unsigned Q0.4 (0 to 15/16)
- mem_addr  output  address_width+1  RAM address {frame_ptr, ch}; ch 0 is left, 1 is right
- mem_we  output  1  RAM write enable
- mem_wdata  output  d_width  RAM write data
- mem_rdata  input  d_width  RAM read data; valid one cycle after the address is presented
- o_valid  output  1  single-cycle output strobe
- o_l_data  output  d_width  left output, signed
- o_r_data  output  d_width  right output, signed
- busy  output  1  high when the FSM is not in IDLE
- overrun  output  1  sticky; set by an i_valid that is dropped

## Operation
- States: INIT, IDLE, RD_L, RD_R, MIX, WR_L, WR_R, DONE.
- INIT (entered on reset release):
  - Writes zero to all 2*ram_depth addresses, ascending from 0, one write per cycle.
  - Then goes to IDLE.
- IDLE, on i_valid:
  - Latch i_l_data, i_r_data, delay_len and gain.
  - rd_ptr = (wr_ptr - delay_len) mod ram_depth.
  - Go to RD_L.
- Read and write sequence:
  - RD_L presents {rd_ptr,0}.
  - RD_R presents {rd_ptr,1} and captures the left delayed sample.
  - MIX captures the right delayed sample.
  - WR_L writes {wr_ptr,0}, then WR_R writes {wr_ptr,1}.
  - DONE pulses o_valid, increments wr_ptr mod ram_depth and returns to IDLE.
- Arithmetic, per channel:
  - wet = (delayed * gain) >>> 4, computed at full product width, arithmetic shift.
  - mix = in + wet, saturated to d_width (clamp to 2^(d_width-1)-1 or -2^(d_width-1)).
- o_l_data and o_r_data register the mix values at the end of WR_R and hold until the next DONE.
- gain = 0: outputs equal the inputs exactly.
- delay_len = 0: reads the slot about to be overwritten, giving a ram_depth-frame delay.
- wr_ptr wraps from ram_depth-1 to 0.
- i_valid while busy: the frame is dropped, overrun is set, and the FSM is unaffected.
- overrun is cleared only by reset.
- mem_we is high only in INIT, WR_L and WR_R.

## Timing
- Reset values:
  - Outputs: mem_addr 0, mem_we 0, mem_wdata 0, o_valid 0, o_l_data 0, o_r_data 0, overrun 0.
  - busy is 1 during reset, since the FSM resets into INIT.
  - Internal: wr_ptr 0.
- INIT lasts 2*ram_depth cycles, during which busy is 1.
- An i_valid sampled at edge k gives:
  - RD_L in cycle k+1
  - RD_R in k+2
  - MIX in k+3
  - WR_L in k+4
  - WR_R in k+5
  - DONE, with o_valid high, in k+6.
- Latency is 6 cycles. Minimum frame spacing is 7 cycles.
- i_valid coinciding with DONE is dropped and counts as an overrun. i_valid is accepted only in IDLE.
- Reset asserted mid-frame:
  - Immediate return to reset values; any partial RAM write is abandoned.
  - On release, full INIT.
  - No o_valid is produced for the interrupted frame.

## Configuration
- FEEDBACK_EN defined: WR_L and WR_R write the saturated mix values, giving a recirculating echo that decays by gain per pass.
- FEEDBACK_EN undefined: WR_L and WR_R write the latched dry inputs, giving a single echo.
- Output mix, latency and FSM sequence are identical in both builds.

## Test plan
- Init: release reset, hold i_valid low -> busy high for exactly 32 cycles (default parameters), 32 zero writes to addresses 0..31, then busy low.
- Impulse: gain 8, delay_len 3, left input 0x100000 in frame 0 and 0 thereafter -> o_l_data 0x100000 at frame 0 and 0x080000 at frame 3. With FEEDBACK_EN, also 0x040000 at frame 6; without it, 0 at frame 6.
- Saturation: gain 15, delay_len 1, left input 0x7FFFFF for every frame -> o_l_data saturates at 0x7FFFFF from frame 1 onwards, with no wrap to negative.
- Latency and overrun: second i_valid 3 cycles after the first -> exactly one o_valid, 6 cycles after the first i_valid; overrun is 1 and stays 1.
- Wrap: delay_len 0, gain 15, 40 frames of an incrementing ramp -> the echo at frame n carries input n-16. mem_addr frame field wraps 15 -> 0.
- Mid-frame reset: assert reset in MIX -> outputs are 0 immediately, no o_valid, a new 32-cycle INIT on release, and the next frame's echo reads zeros.

Source files
------------

// File: rtl/echo_controller.sv
// echo_controller
//   Stereo echo sequencer. Once per audio frame it reads a delayed L/R pair
//   from an external single-port sample RAM used as a circular delay line
//   (left/right interleaved), mixes it with the incoming pair at a
//   programmable gain, writes the new pair back and presents the mix.
//
//   Build option: FEEDBACK_EN
//     defined   : the delay line is written with the saturated mix
//                 (recirculating echo that decays by gain per pass)
//     undefined : the delay line is written with the dry input (single echo)
//
// Ports
//   clk        system clock
//   reset      asynchronous active-low reset
//   i_valid    single-cycle frame strobe, accepted only in IDLE
//   i_l_data   left input sample (signed)
//   i_r_data   right input sample (signed)
//   delay_len  delay in frames, 0 selects ram_depth frames
//   gain       echo gain, unsigned Q0.4
//   mem_addr   RAM address {frame_ptr, ch}, ch 0 = left, 1 = right
//   mem_we     RAM write enable
//   mem_wdata  RAM write data
//   mem_rdata  RAM read data, valid one cycle after the address
//   o_valid    single-cycle output strobe
//   o_l_data   left mixed output (signed), held until the next frame
//   o_r_data   right mixed output (signed), held until the next frame
//   busy       FSM is not in IDLE
//   overrun    sticky, set by a dropped i_valid, cleared only by reset

module echo_controller #(
  parameter int d_width       = 24,
  parameter int address_width = 4,
  parameter int ram_depth     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  input  logic [d_width-1:0]       i_l_data,
  input  logic [d_width-1:0]       i_r_data,
  input  logic [address_width-1:0] delay_len,
  input  logic [3:0]               gain,
  output logic [address_width:0]   mem_addr,
  output logic                     mem_we,
  output logic [d_width-1:0]       mem_wdata,
  input  logic [d_width-1:0]       mem_rdata,
  output logic                     o_valid,
  output logic [d_width-1:0]       o_l_data,
  output logic [d_width-1:0]       o_r_data,
  output logic                     busy,
  output logic                     overrun
);

  // state | meaning
  // ------+---------------------------------------------------------
  // INIT  | clear all 2*ram_depth RAM words, ascending, one per cycle
  // IDLE  | wait for i_valid, latch inputs and compute read pointer
  // RD_L  | present {rd_ptr,0}
  // RD_R  | present {rd_ptr,1}, capture delayed left
  // MIX   | capture delayed right
  // WR_L  | write {wr_ptr,0}
  // WR_R  | write {wr_ptr,1}, register the mixed outputs
  // DONE  | o_valid high, advance wr_ptr
  typedef enum logic [2:0] {
    INIT, IDLE, RD_L, RD_R, MIX, WR_L, WR_R, DONE
  } state_t;

  localparam int CW = address_width + 2;
  localparam logic [CW-1:0] INIT_LEN = CW'(2 * ram_depth);

  state_t                   state_q, state_d;
  logic [CW-1:0]            init_cnt_q, init_cnt_d;
  logic [address_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [address_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [d_width-1:0]       in_l_q, in_l_d;
  logic [d_width-1:0]       in_r_q, in_r_d;
  logic [3:0]               gain_q, gain_d;
  logic [d_width-1:0]       del_l_q, del_l_d;
  logic [d_width-1:0]       del_r_q, del_r_d;
  logic [address_width:0]   mem_addr_q, mem_addr_d;
  logic                     mem_we_q, mem_we_d;
  logic [d_width-1:0]       mem_wdata_q, mem_wdata_d;
  logic                     o_valid_q, o_valid_d;
  logic [d_width-1:0]       o_l_q, o_l_d;
  logic [d_width-1:0]       o_r_q, o_r_d;
  logic                     overrun_q, overrun_d;

  logic [d_width-1:0]       mix_l, mix_r;
  logic [d_width-1:0]       wr_l_data, wr_r_data;

  // in + ((delayed * gain) >>> 4), clamped to the signed d_width range.
  // Gain is zero-extended so the product stays signed.
  function automatic logic [d_width-1:0] mix_sat(
    input logic [d_width-1:0] dry,
    input logic [d_width-1:0] dly,
    input logic [3:0]         g
  );
    logic signed [d_width+4:0] prod;
    logic signed [d_width+4:0] sum;
    prod = $signed(dly) * $signed({1'b0, g});
    sum  = $signed(dry) + (prod >>> 4);
    if (sum > $signed({6'b0, {(d_width-1){1'b1}}}))
      return {1'b0, {(d_width-1){1'b1}}};
    else if (sum < $signed({6'b111111, {(d_width-1){1'b0}}}))
      return {1'b1, {(d_width-1){1'b0}}};
    else
      return sum[d_width-1:0];
  endfunction

  assign mix_l = mix_sat(in_l_q, del_l_q, gain_q);
  assign mix_r = mix_sat(in_r_q, del_r_q, gain_q);

`ifdef FEEDBACK_EN
  assign wr_l_data = mix_l;
  assign wr_r_data = mix_r;
`else
  assign wr_l_data = in_l_q;
  assign wr_r_data = in_r_q;
`endif

  // Memory-side and output registers are loaded from the next-state
  // decision so they line up with state_q and read zero during reset.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    in_l_d      = in_l_q;
    in_r_d      = in_r_q;
    gain_d      = gain_q;
    del_l_d     = del_l_q;
    del_r_d     = del_r_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    o_valid_d   = 1'b0;
    o_l_d       = o_l_q;
    o_r_d       = o_r_q;
    overrun_d   = overrun_q | (i_valid & (state_q != IDLE));

    case (state_q)
      INIT: begin
        if (init_cnt_q != '0) begin
          // Down-counter from 2*ram_depth; its negation walks 0 .. 2*ram_depth-1.
          mem_we_d    = 1'b1;
          mem_addr_d  = -init_cnt_q[address_width:0];
          mem_wdata_d = '0;
          init_cnt_d  = init_cnt_q - CW'(1);
        end else begin
          mem_addr_d = '0;
          state_d    = IDLE;
        end
      end
      IDLE: begin
        if (i_valid) begin
          in_l_d     = i_l_data;
          in_r_d     = i_r_data;
          gain_d     = gain;
          // delay_len is only needed to form the read pointer, so the
          // pointer itself is what gets held for the frame.
          rd_ptr_d   = wr_ptr_q - delay_len;
          mem_addr_d = {wr_ptr_q - delay_len, 1'b0};
          state_d    = RD_L;
        end
      end
      RD_L: begin
        mem_addr_d = {rd_ptr_q, 1'b1};
        state_d    = RD_R;
      end
      RD_R: begin
        del_l_d = mem_rdata;
        state_d = MIX;
      end
      MIX: begin
        del_r_d     = mem_rdata;
        mem_we_d    = 1'b1;
        mem_addr_d  = {wr_ptr_q, 1'b0};
        mem_wdata_d = wr_l_data;
        state_d     = WR_L;
      end
      WR_L: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = {wr_ptr_q, 1'b1};
        mem_wdata_d = wr_r_data;
        state_d     = WR_R;
      end
      WR_R: begin
        o_l_d     = mix_l;
        o_r_d     = mix_r;
        o_valid_d = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        wr_ptr_d = wr_ptr_q + address_width'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      init_cnt_q  <= INIT_LEN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_l_q      <= '0;
      in_r_q      <= '0;
      gain_q      <= '0;
      del_l_q     <= '0;
      del_r_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      o_valid_q   <= 1'b0;
      o_l_q       <= '0;
      o_r_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_l_q      <= in_l_d;
      in_r_q      <= in_r_d;
      gain_q      <= gain_d;
      del_l_q     <= del_l_d;
      del_r_q     <= del_r_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      o_valid_q   <= o_valid_d;
      o_l_q       <= o_l_d;
      o_r_q       <= o_r_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign o_valid   = o_valid_q;
  assign o_l_data  = o_l_q;
  assign o_r_data  = o_r_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_echo_controller.sv
// Bench for echo_controller: behavioural sample RAM, table-driven frames with
// a scoreboard queue of expected outputs, plus hand-written corner sequences.

module tb_echo_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_valid = 1'b0;
  logic [23:0] i_l_data = '0;
  logic [23:0] i_r_data = '0;
  logic [3:0]  delay_len = '0;
  logic [3:0]  gain = '0;
  logic [4:0]  mem_addr;
  logic        mem_we;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata = '0;
  logic        o_valid;
  logic [23:0] o_l_data;
  logic [23:0] o_r_data;
  logic        busy;
  logic        overrun;

  echo_controller #(.d_width(24), .address_width(4), .ram_depth(16)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid),
    .i_l_data(i_l_data), .i_r_data(i_r_data),
    .delay_len(delay_len), .gain(gain),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .o_valid(o_valid), .o_l_data(o_l_data), .o_r_data(o_r_data),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Synchronous-read single-port RAM
  logic [23:0] ram [32];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_ovalid = 0;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          cyc;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [3:0]  dl;
    logic [3:0]  g;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;
  vec_t vecs[13];

  logic [3:0] model_wr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      n_ovalid++;
      if (sbq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_o_valid: got o_valid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("o_valid_cycle", cyc, mon_e.cyc);
        chk("o_l_data", o_l_data, mon_e.l);
        chk("o_r_data", o_r_data, mon_e.r);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] bmix(input logic [23:0] din, input logic [23:0] ddl,
                                       input logic [3:0] g);
    longint a, b, s;
    a = longint'($signed(din));
    b = longint'($signed(ddl));
    s = a + ((b * longint'(g)) >>> 4);
    if (s > 64'sd8388607) s = 64'sd8388607;
    else if (s < -64'sd8388608) s = -64'sd8388608;
    return s[23:0];
  endfunction

  task automatic chk_reset_vals();
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_l_data", o_l_data, 0);
    chk("rst_o_r_data", o_r_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 1);
  endtask

  // Hold reset, check reset values, release and follow the full INIT sweep.
  task automatic do_reset();
    reset = 1'b0;
    i_valid = 1'b0;
    repeat (3) tick();
    chk_reset_vals();
    reset = 1'b1;
    model_wr = '0;
    for (int n = 0; n < 32; n++) begin
      tick();
      chk("init_we", mem_we, 1);
      chk("init_addr", mem_addr, n);
      chk("init_wdata", mem_wdata, 0);
      chk("init_busy", busy, 1);
    end
    tick();
    chk("init_end_busy", busy, 0);
    chk("init_end_we", mem_we, 0);
  endtask

  // One accepted frame at minimum spacing; returns in IDLE after DONE.
  task automatic send(input logic [23:0] l, input logic [23:0] r, input logic [3:0] dl,
                      input logic [3:0] g, input logic [23:0] el, input logic [23:0] er);
    logic [3:0]  rd;
    logic [23:0] wl, wrr;
    exp_t        e;
    rd = model_wr - dl;
`ifdef FEEDBACK_EN
    wl = el; wrr = er;
`else
    wl = l; wrr = r;
`endif
    i_valid = 1'b1; i_l_data = l; i_r_data = r; delay_len = dl; gain = g;
    tick();
    i_valid = 1'b0;
    e.l = el; e.r = er; e.cyc = cyc + 5;
    sbq.push_back(e);
    chk("rd_l_addr", mem_addr, {rd, 1'b0});
    chk("rd_l_we", mem_we, 0);
    tick();
    chk("rd_r_addr", mem_addr, {rd, 1'b1});
    tick();
    tick();
    chk("wr_l_we", mem_we, 1);
    chk("wr_l_addr", mem_addr, {model_wr, 1'b0});
    chk("wr_l_data", mem_wdata, wl);
    tick();
    chk("wr_r_we", mem_we, 1);
    chk("wr_r_addr", mem_addr, {model_wr, 1'b1});
    chk("wr_r_data", mem_wdata, wrr);
    tick();
    tick();
    model_wr = model_wr + 4'd1;
  endtask

  initial begin
    logic [23:0] hl [16];
    logic [23:0] hr [16];
    logic [23:0] l, r, el, er;
    int          k, ov0;

    // impulse: gain 8, delay 3
    vecs[0] = '{24'h100000, 24'hF00000, 4'd3, 4'd8, 24'h100000, 24'hF00000};
    vecs[1] = '{24'h000000, 24'h000000, 4'd3, 4'd8, 24'h000000, 24'h000000};
    vecs[2] = '{24'h000000, 24'h000000, 4'd3, 4'd8, 24'h000000, 24'h000000};
    vecs[3] = '{24'h000000, 24'h000000, 4'd3, 4'd8, 24'h080000, 24'hF80000};
    vecs[4] = '{24'h000000, 24'h000000, 4'd3, 4'd8, 24'h000000, 24'h000000};
    vecs[5] = '{24'h000000, 24'h000000, 4'd3, 4'd8, 24'h000000, 24'h000000};
`ifdef FEEDBACK_EN
    vecs[6] = '{24'h000000, 24'h000000, 4'd3, 4'd8, 24'h040000, 24'hFC0000};
`else
    vecs[6] = '{24'h000000, 24'h000000, 4'd3, 4'd8, 24'h000000, 24'h000000};
`endif
    vecs[7] = '{24'h000000, 24'h000000, 4'd3, 4'd8, 24'h000000, 24'h000000};
    // saturation: gain 15, delay 1, full-scale inputs
    for (int i = 8; i < 13; i++)
      vecs[i] = '{24'h7FFFFF, 24'h800000, 4'd1, 4'd15, 24'h7FFFFF, 24'h800000};

    do_reset();

    for (int i = 0; i < 8; i++)
      send(vecs[i].l, vecs[i].r, vecs[i].dl, vecs[i].g, vecs[i].el, vecs[i].er);

    do_reset();
    for (int i = 8; i < 13; i++)
      send(vecs[i].l, vecs[i].r, vecs[i].dl, vecs[i].g, vecs[i].el, vecs[i].er);
    repeat (5) tick();
    chk("hold_o_l_data", o_l_data, 24'h7FFFFF);
    chk("hold_o_r_data", o_r_data, 24'h800000);

    // latency / overrun: second strobe 3 cycles later, third in DONE
    do_reset();
    ov0 = n_ovalid;
    i_valid = 1'b1; i_l_data = 24'h123456; i_r_data = 24'hFEDCBA; delay_len = 4'd1; gain = 4'd0;
    tick();
    i_valid = 1'b0;
    k = cyc;
    sbq.push_back('{24'h123456, 24'hFEDCBA, k + 5});
    chk("ovr_first_accept", overrun, 0);
    tick(); tick();
    i_valid = 1'b1; i_l_data = 24'h555555; i_r_data = 24'h222222;
    tick();
    i_valid = 1'b0;
    chk("ovr_set", overrun, 1);
    chk("ovr_busy", busy, 1);
    tick(); tick();
    i_valid = 1'b1; i_l_data = 24'h333333;
    tick();
    i_valid = 1'b0;
    chk("done_drop_idle", busy, 0);
    repeat (8) tick();
    chk("ovr_single_o_valid", n_ovalid - ov0, 1);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_hold_o_l", o_l_data, 24'h123456);
    model_wr = model_wr + 4'd1;

    // ramp with maximum delay
    do_reset();
    for (int i = 0; i < 16; i++) begin hl[i] = '0; hr[i] = '0; end
    for (int n = 0; n < 40; n++) begin
      l  = 24'((n + 1) * 4096);
      r  = 24'(-(n + 1) * 4096);
      el = bmix(l, hl[model_wr], 4'd15);
      er = bmix(r, hr[model_wr], 4'd15);
`ifdef FEEDBACK_EN
      hl[model_wr] = el; hr[model_wr] = er;
`else
      hl[model_wr] = l;  hr[model_wr] = r;
`endif
      send(l, r, 4'd0, 4'd15, el, er);
    end

    // mid-frame reset while in MIX
    i_valid = 1'b1; i_l_data = 24'h0ABCDE; i_r_data = 24'h0EDCBA; delay_len = 4'd0; gain = 4'd15;
    tick();
    i_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk_reset_vals();
    do_reset();
    send(24'h012345, 24'h054321, 4'd0, 4'd15, 24'h012345, 24'h054321);

    repeat (4) tick();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
